pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits ({PC[31:0], instr[31:0]} for the IF/ID boundary).
REQ-002 Parameter CNT_W, default 16, width of the stall counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserting low clears all state immediately.
REQ-005 flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  stage accepts; driven directly from a register, with no combinational path from out_ready.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data is a live entry.
REQ-010 out_ready  input  1  downstream consumes when out_valid is also high.
REQ-011 out_data  output  WIDTH  oldest held entry.
REQ-012 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 Transfer rules:
- An input transfer occurs when in_valid and in_ready are both high.
- An output transfer occurs when out_valid and out_ready are both high.
REQ-014 Storage is two entries, main and skid; out_data is always driven from main.
REQ-015 The FSM has three states:
- EMPTY: no entries.
- ONE: main holds an entry.
- TWO: main and skid both hold entries.
REQ-016 Outputs per state:
- out_valid = 1 in ONE and TWO.
- in_ready = 0 only in TWO.
REQ-017 Transitions out of EMPTY: input transfer -> ONE, with main loaded; otherwise stay in EMPTY.
REQ-018 Transitions out of ONE:
- input transfer, no output transfer -> TWO, with skid loaded.
- output transfer, no input transfer -> EMPTY.
- both -> ONE, with main loaded from in_data.
- neither -> ONE, hold.
REQ-019 Transitions out of TWO: output transfer -> ONE, with main loaded from skid; otherwise hold.
REQ-020 Latency: an entry accepted at edge N is presented on out_data/out_valid after edge N, provided the stage was EMPTY or was ONE with a simultaneous output transfer.
REQ-021 Entries leave in strict acceptance order; none is dropped or duplicated absent flush.
REQ-022 Flush:
- flush=1 at an edge forces EMPTY and discards main, skid and any same-cycle input.
- Flush has priority over all transfers.
- in_ready is 1 on the following cycle.
REQ-023 When invalid, out_data holds its last value; consumers treat it as don't-care.
REQ-024 stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0.
- It saturates at all-ones and does not wrap.
- It is unaffected by flush.

Reset
REQ-025 While rst=0:
- The state is EMPTY.
- in_ready=1, out_valid=0.
- out_data is 0 and the skid register is 0.
- stall_cnt is 0.
REQ-026 Reset mid-operation discards every held entry with no partial transfer.
REQ-027 Normal operation starts at the first rising edge after rst returns high.

Structure
REQ-028 The state encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) are defined in defines.v.
REQ-029 defines.v also holds the RISC-V NOP constant 32'h00000013, used by benches as filler payload.
REQ-030 One sub-module, reg_en_w, is used for the main and skid storage:
- WIDTH-bit register.
- Load enable.
- Asynchronous active-low clear.
REQ-031 The FSM and stall counter are implemented inline in pipe_skid_reg.

Verification
REQ-032 Flow-through: after reset, in_valid=1 on every cycle with payloads 1,2,3,4 and out_ready=1 throughout.
- Required: out_data is 1,2,3,4 on consecutive cycles, one cycle after each is accepted.
- Required: in_ready stays at 1 throughout.
REQ-033 Backpressure: accept A, then B with out_ready=0 for 3 cycles.
- Required: the state reaches TWO and in_ready=0.
- Required: stall_cnt=3.
- Then raise out_ready: A is seen, then B; in_ready returns to 1 one cycle after A leaves.
REQ-034 Flush in TWO with in_valid=1 and payload C on the same edge.
- Required: out_valid=0 next cycle and in_ready=1.
- Required: C never appears at the output.
REQ-035 Asynchronous reset: drop rst low mid-cycle while in ONE.
- Required: out_valid and stall_cnt fall to 0 before the next edge.
- Required: no stale entry appears after reset is released.
REQ-036 Saturation: with CNT_W=4, hold a stall for 20 cycles.
- Required: stall_cnt=4'hF and stays there.
REQ-037 Random traffic: 10,000 cycles of random in_valid/out_ready/flush (about 2% flush), checked against a scoreboard model.
- Required: exact in-order delivery with no loss.
- Required: in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: state encoding and filler payload shared by the skid stage and its benches
package pipe_skid_reg_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    localparam logic [31:0] NOP = 32'h00000013;
endpackage

// File: rtl/pipe_skid_reg_reg_en_w.sv
// reg_en_w: WIDTH-bit register with load enable and asynchronous active-low clear
module reg_en_w #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid pipeline register with registered in_ready, flush and saturating stall counter
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t           state;
    logic [WIDTH-1:0] skid;
    logic             in_xfer, out_xfer, main_en, skid_en;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    // main refills from skid when draining TWO, otherwise straight from the input
    assign main_en  = !flush && (state == EMPTY ? in_xfer :
                                 state == ONE   ? in_xfer && out_xfer : out_xfer);
    assign skid_en  = !flush && state == ONE && in_xfer && !out_xfer;
    reg_en_w #(.WIDTH(WIDTH)) u_main (
        .clk(clk), .rst(rst), .en(main_en),
        .d(state == TWO ? skid : in_data), .q(out_data)
    );
    reg_en_w #(.WIDTH(WIDTH)) u_skid (
        .clk(clk), .rst(rst), .en(skid_en), .d(in_data), .q(skid)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst || flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    state     <= ONE;
                    out_valid <= 1'b1;
                end
                ONE: if (in_xfer && !out_xfer) begin
                    state    <= TWO;
                    in_ready <= 1'b0;
                end else if (out_xfer && !in_xfer) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
                TWO: if (out_xfer) begin
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random traffic against a queue-based scoreboard
module tb_pipe_skid_reg;
    import pipe_skid_reg_pkg::*;
    localparam int W  = 64;
    localparam int CW = 4;
    localparam logic [W-1:0] FILL = {32'h0, NOP};

    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [W-1:0]  in_data = '0, out_data;
    logic [CW-1:0] stall_cnt;

    logic [W-1:0]  q[$];
    logic [CW-1:0] exp_stall = '0;
    int checks = 0, errors = 0, push_now = 0, occ = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Monitor: the model's occupancy is the queue minus anything pushed this cycle
    always @(negedge clk) if (rst) begin
        occ = q.size() - push_now;
        chk("out_valid", out_valid, occ > 0);
        chk("in_ready", in_ready, occ < 2);
        chk("stall_cnt", stall_cnt, exp_stall);
        if (occ > 0) chk("out_data", out_data, q[0]);
        if (occ > 0 && !out_ready && exp_stall != '1) exp_stall = exp_stall + 1'b1;
        if (flush) q.delete();
        else if (occ > 0 && out_ready) void'(q.pop_front());
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic ir;
        ir = in_ready;
        in_valid = v; in_data = d; out_ready = r; flush = f;
        push_now = (v && ir && !f) ? 1 : 0;
        if (push_now != 0) q.push_back(d);
        #1 chk("in_ready_vs_out_ready", in_ready, ir);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 0; in_valid = 0; out_ready = 0; flush = 0; in_data = FILL;
        push_now = 0; q.delete(); exp_stall = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        #2 do_reset();
        // flow-through
        for (int i = 1; i <= 4; i++) drive(1, W'(i), 1, 0);
        repeat (2) drive(0, FILL, 1, 0);
        // backpressure
        do_reset();
        drive(1, 64'hAAAA, 0, 0);
        drive(1, 64'hBBBB, 0, 0);
        repeat (2) drive(0, FILL, 0, 0);
        chk("bp_stall_cnt", stall_cnt, 3);
        chk("bp_in_ready", in_ready, 0);
        drive(0, FILL, 1, 0);
        chk("bp_in_ready_after_a", in_ready, 1);
        repeat (2) drive(0, FILL, 1, 0);
        // flush in TWO with a same-edge input
        do_reset();
        drive(1, 64'hA1, 0, 0);
        drive(1, 64'hB1, 0, 0);
        drive(1, 64'hC1, 0, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (3) drive(0, FILL, 1, 0);
        // asynchronous reset mid-cycle while in ONE
        do_reset();
        drive(1, 64'hD1, 0, 0);
        drive(0, FILL, 0, 0);
        #2 do_reset();
        repeat (3) drive(0, FILL, 1, 0);
        // stall counter saturation
        do_reset();
        drive(1, 64'hE1, 0, 0);
        repeat (20) drive(0, FILL, 0, 0);
        chk("sat_stall_cnt", stall_cnt, 4'hF);
        repeat (3) drive(0, FILL, 0, 0);
        chk("sat_stall_hold", stall_cnt, 4'hF);
        repeat (2) drive(0, FILL, 1, 0);
        // random traffic
        do_reset();
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        repeat (4) drive(0, FILL, 1, 0);
        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
